rotate_cmd_queue: RTL and testbench

// - Buffers rotate commands {data, amt} in a small FIFO with a valid/ready input handshake.
// - The FIFO head drives the combinational 8-bit rotate-right stage. Its result is captured
//   in a registered output slot with a valid/ready handshake.
// - Sits directly upstream of the rotator, which it feeds, and directly downstream of it,

---
 rtl/rotate_cmd_queue_if.sv | 36 +++
 rtl/rotate_cmd_queue.sv | 127 ++++++++++++
 tb/tb_rotate_cmd_queue.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rotate_cmd_queue_if.sv
// Command-in / rotator / result-out signal bundle for rotate_cmd_queue.
// ROTATE_CMD_LEFT_EN adds the per-command direction bit in_dir.
interface rotate_cmd_queue_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
`ifdef ROTATE_CMD_LEFT_EN
    logic       in_dir;
`endif
    logic [7:0] rot_data;
    logic [2:0] rot_amt;
    logic [7:0] rot_f;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_amt;

    // The queue itself: consumes commands and rotator results, produces results.
    modport slave (
`ifdef ROTATE_CMD_LEFT_EN
        input  in_dir,
`endif
        input  in_valid, in_data, in_amt, rot_f, out_ready,
        output in_ready, rot_data, rot_amt, out_valid, out_data, out_amt
    );

    // Surrounding environment: command source, rotator and result consumer.
    modport master (
`ifdef ROTATE_CMD_LEFT_EN
        output in_dir,
`endif
        output in_valid, in_data, in_amt, rot_f, out_ready,
        input  in_ready, rot_data, rot_amt, out_valid, out_data, out_amt
    );
endinterface

// File: rtl/rotate_cmd_queue.sv
// Command FIFO feeding an external 8-bit rotate-right stage, with a registered result slot.
// Define ROTATE_CMD_LEFT_EN to add a per-command left-rotate direction bit (in_dir).
module rotate_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    rotate_cmd_queue_if.slave        bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         done_cnt
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OCC_W   = PTR_W + 1;
`ifdef ROTATE_CMD_LEFT_EN
    localparam int ENTRY_W = 12;
`else
    localparam int ENTRY_W = 11;
`endif

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_data_q, out_data_d;
    logic [2:0]         out_amt_q, out_amt_d;

    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;
    logic [7:0]         head_data;
    logic [2:0]         head_amt;
    logic               not_empty;
    logic               in_ready_w;
    logic               push;
    logic               load;
    logic               handoff;

`ifdef ROTATE_CMD_LEFT_EN
    assign wr_entry = {bus.in_dir, bus.in_data, bus.in_amt};
    // Left by k is right by (8-k) mod 8; the 3-bit subtraction gives exactly that.
    assign head_amt = head[11] ? (3'd0 - head[2:0]) : head[2:0];
`else
    assign wr_entry = {bus.in_data, bus.in_amt};
    assign head_amt = head[2:0];
`endif

    assign head      = mem_q[rd_ptr_q];
    assign head_data = head[10:3];
    assign not_empty = (count_q != '0);

    // No bypass: a pop in the same cycle never frees a slot for a push.
    assign in_ready_w = rst_n && (count_q < OCC_W'(DEPTH));
    assign push       = bus.in_valid && in_ready_w;
    assign load       = not_empty && (!out_valid_q || bus.out_ready);
    assign handoff    = out_valid_q && bus.out_ready;

    assign bus.in_ready  = in_ready_w;
    assign bus.rot_data  = not_empty ? head_data : 8'd0;
    assign bus.rot_amt   = not_empty ? head_amt : 3'd0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_amt   = out_amt_q;
    assign count         = count_q;
    assign done_cnt      = done_cnt_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        done_cnt_d  = done_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_amt_d   = out_amt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (load) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            out_valid_d = 1'b1;
            out_data_d  = bus.rot_f;
            out_amt_d   = head_amt;
        end else if (handoff) begin
            out_valid_d = 1'b0;
        end

        case ({push, load})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase

        if (handoff) begin
            done_cnt_d = done_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            done_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_amt_q   <= 3'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            done_cnt_q  <= done_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_amt_q   <= out_amt_d;
        end
    end

    // Entry storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end
endmodule

// File: tb/tb_rotate_cmd_queue.sv
// Self-checking bench for rotate_cmd_queue: directed table, hand-written corner sequences
// and randomized streaming against a transaction-level queue model.
module tb_rotate_cmd_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic                    clk;
    logic                    rst_n;
    logic [$clog2(DEPTH):0]  count;
    logic [CNT_W-1:0]        done_cnt;

    rotate_cmd_queue_if bus ();

    rotate_cmd_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .count    (count),
        .done_cnt (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External rotator: plain rotate-right of the FIFO head.
    function automatic logic [7:0] rotator(input logic [7:0] d, input logic [2:0] a);
        logic [15:0] t;
        t = {d, d} >> a;
        return t[7:0];
    endfunction
    assign bus.rot_f = rotator(bus.rot_data, bus.rot_amt);

    typedef struct {
        logic [7:0] d;
        logic [2:0] a;
        logic       dir;
    } cmd_t;

    // Reference model state
    cmd_t       fifo_m[$];
    bit         slot_v;
    logic [7:0] slot_d;
    logic [2:0] slot_a;
    int         done_m;
    logic [7:0] got_q[$];
    bit         last_push;

    int vectors;
    int miscompares;

    logic       cur_dir;

    function automatic int eff_amt(input cmd_t c);
        return c.dir ? ((8 - int'(c.a)) % 8) : int'(c.a);
    endfunction

    function automatic int ror_ref(input int d, input int r);
        return ((d >> r) | (d << (8 - r))) & 255;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_cmd(input logic v, input logic [7:0] d, input logic [2:0] a, input logic dir);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_amt   = a;
        cur_dir      = dir;
`ifdef ROTATE_CMD_LEFT_EN
        bus.in_dir   = dir;
`endif
    endtask

    // One clock: pre-edge checks, edge, model update, post-edge checks. Starts/ends at negedge.
    task automatic cycle();
        bit   acc, pop, ho;
        cmd_t c;
        #1;
        chk("in_ready", int'(bus.in_ready), int'(rst_n && (fifo_m.size() < DEPTH)));
        if (rst_n && fifo_m.size() != 0) begin
            chk("rot_data", int'(bus.rot_data), int'(fifo_m[0].d));
            chk("rot_amt", int'(bus.rot_amt), eff_amt(fifo_m[0]));
        end else if (rst_n) begin
            chk("rot_idle", int'({bus.rot_data, bus.rot_amt}), 0);
        end
        acc = bus.in_valid && rst_n && (fifo_m.size() < DEPTH);
        c.d = bus.in_data; c.a = bus.in_amt; c.dir = cur_dir;
        @(posedge clk);
        if (!rst_n) begin
            fifo_m.delete();
            slot_v = 0; slot_d = 0; slot_a = 0; done_m = 0;
            last_push = 0;
        end else begin
            ho  = slot_v && bus.out_ready;
            pop = (fifo_m.size() != 0) && (!slot_v || bus.out_ready);
            if (ho) begin
                done_m++;
                got_q.push_back(slot_d);
            end
            if (pop) begin
                cmd_t h;
                h = fifo_m.pop_front();
                slot_v = 1;
                slot_a = 3'(eff_amt(h));
                slot_d = 8'(ror_ref(int'(h.d), eff_amt(h)));
            end else if (ho) begin
                slot_v = 0;
            end
            if (acc) fifo_m.push_back(c);
            last_push = acc;
        end
        @(negedge clk);
        chk("count", int'(count), fifo_m.size());
        chk("out_valid", int'(bus.out_valid), int'(slot_v));
        chk("done_cnt", int'(done_cnt), done_m % (1 << CNT_W));
        if (slot_v) begin
            chk("out_data", int'(bus.out_data), int'(slot_d));
            chk("out_amt", int'(bus.out_amt), int'(slot_a));
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic [2:0] a;
        logic       dir;
        logic [7:0] exp_d;
        logic [2:0] exp_a;
    } vec_t;

`ifdef ROTATE_CMD_LEFT_EN
    localparam int NVEC = 10;
`else
    localparam int NVEC = 8;
`endif
    vec_t vecs[NVEC];

    initial begin
        logic [7:0] held;
        logic [7:0] exp_order[5];
        int         start_done, sent, cyc;

        vectors = 0; miscompares = 0;
        fifo_m.delete(); got_q.delete();
        slot_v = 0; slot_d = 0; slot_a = 0; done_m = 0; last_push = 0;
        bus.out_ready = 1'b0;
        set_cmd(1'b0, 8'd0, 3'd0, 1'b0);

        vecs[0] = '{8'hB1, 3'd1, 1'b0, 8'hD8, 3'd1};
        vecs[1] = '{8'h01, 3'd1, 1'b0, 8'h80, 3'd1};
        vecs[2] = '{8'h01, 3'd2, 1'b0, 8'h40, 3'd2};
        vecs[3] = '{8'h01, 3'd3, 1'b0, 8'h20, 3'd3};
        vecs[4] = '{8'h01, 3'd0, 1'b0, 8'h01, 3'd0};
        vecs[5] = '{8'hF0, 3'd4, 1'b0, 8'h0F, 3'd4};
        vecs[6] = '{8'h81, 3'd7, 1'b0, 8'h03, 3'd7};
        vecs[7] = '{8'hA5, 3'd5, 1'b0, 8'h2D, 3'd5};
`ifdef ROTATE_CMD_LEFT_EN
        vecs[8] = '{8'h81, 3'd1, 1'b1, 8'h03, 3'd7};
        vecs[9] = '{8'h81, 3'd0, 1'b1, 8'h81, 3'd0};
`endif

        // Reset held two cycles
        rst_n = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        chk("rst_in_ready", int'(bus.in_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_done", int'(done_cnt), 0);
        chk("rst_out_data", int'({bus.out_data, bus.out_amt}), 0);
        chk("post_rst_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);

        // Directed table: accept, result one edge later, hand-off the edge after
        bus.out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            start_done = int'(done_cnt);
            set_cmd(1'b1, vecs[i].d, vecs[i].a, vecs[i].dir);
            cycle();
            chk("tbl_accept", int'(last_push), 1);
            set_cmd(1'b0, 8'd0, 3'd0, 1'b0);
            cycle();
            chk("tbl_valid", int'(bus.out_valid), 1);
            chk("tbl_data", int'(bus.out_data), int'(vecs[i].exp_d));
            chk("tbl_amt", int'(bus.out_amt), int'(vecs[i].exp_a));
            cycle();
            chk("tbl_done", int'(done_cnt), (start_done + 1) % (1 << CNT_W));
        end

        // Fill to full with the consumer stalled; later commands must wait
        bus.out_ready = 1'b0;
        got_q.delete();
        for (int k = 0; k < 4; k++) begin
            set_cmd(1'b1, 8'h01, 3'(k), 1'b0);
            cycle();
        end
        set_cmd(1'b1, 8'h01, 3'd4, 1'b0);
        cycle();
        cycle();
        cycle();
        chk("full_count", int'(count), 4);
        chk("full_in_ready", int'(bus.in_ready), 0);
        set_cmd(1'b0, 8'd0, 3'd0, 1'b0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 12; k++) cycle();
        exp_order[0] = 8'h01; exp_order[1] = 8'h80; exp_order[2] = 8'h40;
        exp_order[3] = 8'h20; exp_order[4] = 8'h10;
        chk("order_len", got_q.size(), 5);
        for (int k = 0; k < 5 && k < got_q.size(); k++) chk("order_data", int'(got_q[k]), int'(exp_order[k]));

        // Stall: result held 5 cycles, then one hand-off per cycle
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_cmd(1'b1, 8'($urandom), 3'($urandom), 1'b0);
            cycle();
        end
        set_cmd(1'b0, 8'd0, 3'd0, 1'b0);
        held = bus.out_data;
        chk("stall_valid", int'(bus.out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("stall_hold", int'(bus.out_data), int'(held));
        end
        bus.out_ready = 1'b1;
        start_done = int'(done_cnt);
        for (int k = 1; k <= 4; k++) begin
            cycle();
            chk("stream_done", int'(done_cnt), (start_done + k) % (1 << CNT_W));
        end
        cycle();

        // Reset mid-operation drops queued commands and the pending result
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_cmd(1'b1, 8'h5A, 3'(k), 1'b0);
            cycle();
        end
        set_cmd(1'b0, 8'd0, 3'd0, 1'b0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("midrst_count", int'(count), 0);
        chk("midrst_valid", int'(bus.out_valid), 0);
        chk("midrst_done", int'(done_cnt), 0);

        // Randomized streaming of 16 commands with random back-pressure
        sent = 0; cyc = 0;
        start_done = int'(done_cnt);
        while ((sent < 16 || fifo_m.size() != 0 || slot_v) && cyc < 2000) begin
            if (sent < 16 && ($urandom % 4) != 0)
                set_cmd(1'b1, 8'($urandom), 3'($urandom),
                        1'($urandom)
`ifndef ROTATE_CMD_LEFT_EN
                        & 1'b0
`endif
                       );
            else
                set_cmd(1'b0, 8'd0, 3'd0, 1'b0);
            bus.out_ready = 1'($urandom);
            cycle();
            if (last_push) sent++;
            cyc++;
        end
        chk("rand_timeout", int'(cyc < 2000), 1);
        chk("rand_done16", int'(done_cnt) - start_done, 16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
